mem_arbiter: RTL
================

# mem_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss paths of the three-stage RISC-V core. It accepts one request at a time from either cache, issues it to memory, and then does one of two things: streams write-data beats from the data cache to memory, or routes read-response beats back to the owning cache. Round-robin arbitration keeps either side from being starved while both are missing.

## Interface
Parameters:
- ADDR_W, 28, memory address width
- DATA_W, 128, width of one data beat
- BEATS, 4, beats per read response and per write; power of two, ≥1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ic_req_valid  in  1  instruction-cache read request
- ic_req_ready  out  1  request accepted this cycle when both valid and ready are high
- ic_req_addr  in  ADDR_W  read address
- ic_resp_valid  out  1  read beat for the instruction cache
- ic_resp_data  out  DATA_W  read beat data
- dc_req_valid  in  1  data-cache request
- dc_req_ready  out  1  request accepted this cycle when both valid and ready are high
- dc_req_rw  in  1  1 = write, 0 = read
- dc_req_addr  in  ADDR_W  request address
- dc_wdata_valid  in  1  write beat offered
- dc_wdata_ready  out  1  write beat accepted
- dc_wdata  in  DATA_W  write beat data
- dc_wmask  in  DATA_W/8  byte mask for the write beat
- dc_resp_valid  out  1  read beat for the data cache
- dc_resp_data  out  DATA_W  read beat data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_rw  out  1  request type, copied from the granted request
- mem_req_addr  out  ADDR_W  request address
- mem_wdata_valid  out  1  write beat to memory
- mem_wdata_ready  in  1  memory accepts the write beat
- mem_wdata  out  DATA_W  write beat data
- mem_wmask  out  DATA_W/8  write beat byte mask
- mem_resp_valid  in  1  read beat from memory
- mem_resp_data  in  DATA_W  read beat data

## Operation
- Registered state: state ∈ {IDLE, REQ, WDATA, RESP}; owner (0 = ic, 1 = dc); latched rw and addr; beat_cnt (clog2(BEATS) bits, min 1); last_grant.
- IDLE:
  - Select a winner among the valid requesters. With one valid, that one wins. With both valid, the one ≠ last_grant wins.
  - The winner's req_ready = 1 (combinational). The other side's req_ready = 0.
  - On the handshake: latch addr and rw (rw forced 0 for ic), owner ← winner, last_grant ← winner, beat_cnt ← 0, go to REQ.
- REQ:
  - mem_req_valid = 1; mem_req_addr and mem_req_rw driven from the registers and held stable until accepted.
  - On mem_req_ready: go to WDATA if rw, else RESP.
- WDATA (owner is always dc):
  - Pass-through: mem_wdata_valid = dc_wdata_valid, dc_wdata_ready = mem_wdata_ready, and mem_wdata/mem_wmask = dc_wdata/dc_wmask.
  - Each handshake increments beat_cnt.
  - The handshake at beat_cnt = BEATS−1 returns to IDLE. No read response is produced.
- RESP:
  - Pass-through to the owner: owner_resp_valid = mem_resp_valid, owner_resp_data = mem_resp_data. There is no backpressure.
  - Each mem_resp_valid increments beat_cnt. The beat at beat_cnt = BEATS−1 returns to IDLE.
- Outside RESP, mem_resp_valid is ignored and both resp_valid outputs are 0.
- Outside WDATA, dc_wdata_ready = 0 and mem_wdata_valid = 0.
- Outside REQ, mem_req_valid = 0.
- Outside IDLE, both req_ready outputs = 0.
- resp_data outputs are don't-care while the matching resp_valid = 0.
- beat_cnt wraps naturally. Its exit compare uses the current value before the increment.

## Timing
- Reset:
  - While reset is high, all valid and ready outputs are 0.
  - On the clock edge with reset high: state ← IDLE, beat_cnt ← 0, owner ← 0, last_grant ← 0 (ic), so dc wins the first tie.
  - Reset mid-transaction abandons it. Later memory beats from that transaction are ignored in IDLE.
- Latency:
  - Request handshake at cycle N → mem_req_valid at N+1.
  - mem_req handshake at cycle M → WDATA/RESP active from M+1.
  - A response beat appears on resp_valid in the same cycle it arrives (combinational).
- Turnaround: final beat at cycle K → IDLE at K+1. A new grant can occur at K+1 and mem_req_valid at K+2.
- Only one transaction is outstanding. A requester holding valid in a non-IDLE state waits, with ready = 0.
- A write beat offered during REQ is not accepted (dc_wdata_ready = 0).
- Simultaneous new request and final beat: the request is not granted until the following IDLE cycle.

## Test plan
- ic read alone:
  - Stimulus: ic_req_addr = 0x0000100; mem_req_ready = 1 immediately; beats D0–D3 on consecutive cycles.
  - Required: mem_req_valid exactly 1 cycle with addr 0x0000100 and rw = 0; ic_resp_valid for 4 cycles carrying D0–D3; dc_resp_valid = 0; IDLE afterwards.
- Contention:
  - Stimulus: ic and dc reads both held valid from the first post-reset cycle.
  - Required: grants go dc, ic, dc, ic. The losing side's req_ready stays 0 throughout each transaction, and each response goes only to its owner.
- dc write with memory backpressure:
  - Stimulus: mem_wdata_ready toggles each cycle; 4 beats with mask 0xFFFF.
  - Required: exactly 4 handshakes; mem_wdata equals dc_wdata on each; mem_req_rw = 1; no resp_valid; IDLE after the 4th handshake.
- Request backpressure:
  - Stimulus: mem_req_ready held 0 for 5 cycles.
  - Required: mem_req_valid = 1 and mem_req_addr unchanged for all 6 cycles; the handshake happens on the 6th cycle.
- Reset mid-RESP:
  - Stimulus: reset asserted after 2 of 4 beats; memory then sends the remaining 2 beats.
  - Required: all valids and readies = 0 during reset; the 2 stray beats produce no resp_valid; a subsequent tie grants dc.
- Stray response:
  - Stimulus: mem_resp_valid pulsed while IDLE and while in REQ.
  - Required: ic_resp_valid = dc_resp_valid = 0; beat_cnt unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache and D-cache
// miss paths. One transaction at a time: grant, issue request, then either
// stream D-cache write beats to memory or route read beats to the owner.
//
// Handshakes: every *_valid/*_ready pair transfers exactly one item in a
// cycle where both are high. A valid, once raised, is held with its payload
// until that transfer. Ready never depends on the state of the item being
// offered beyond the arbiter's own state, and both are forced low in reset.
module mem_arbiter #(
   parameter  int ADDR_W = 28,
   parameter  int DATA_W = 128,
   parameter  int BEATS  = 4,
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   // instruction-cache miss path (read only)
   input  logic                  ic_req_valid,
   output logic                  ic_req_ready,
   input  logic [ADDR_W-1:0]     ic_req_addr,
   output logic                  ic_resp_valid,
   output logic [DATA_W-1:0]     ic_resp_data,
   // data-cache miss/writeback path
   input  logic                  dc_req_valid,
   output logic                  dc_req_ready,
   input  logic                  dc_req_rw,
   input  logic [ADDR_W-1:0]     dc_req_addr,
   input  logic                  dc_wdata_valid,
   output logic                  dc_wdata_ready,
   input  logic [DATA_W-1:0]     dc_wdata,
   input  logic [DATA_W/8-1:0]   dc_wmask,
   output logic                  dc_resp_valid,
   output logic [DATA_W-1:0]     dc_resp_data,
   // main-memory port
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_rw,
   output logic [ADDR_W-1:0]     mem_req_addr,
   output logic                  mem_wdata_valid,
   input  logic                  mem_wdata_ready,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_resp_data,
   // observation of internal state (0 IDLE, 1 REQ, 2 WDATA, 3 RESP)
   output logic [1:0]            o_dbg_state,
   output logic [CNT_W-1:0]      o_dbg_beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WDATA = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_owner;       // 0 = ic, 1 = dc
   logic                r_last_grant;  // 0 = ic, 1 = dc
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [CNT_W-1:0]    r_beat_cnt;

   logic                w_run;
   logic                w_grant_dc;
   logic                w_req_fire;
   logic                w_beat_fire;
   logic                w_last_beat;

   // Outputs are silenced while reset is high, even before the edge lands.
   assign w_run       = ~reset;
   // dc wins when it is the only requester, or on a tie when ic went last.
   assign w_grant_dc  = dc_req_valid & (~ic_req_valid | ~r_last_grant);
   // Exit compare uses the count before this beat's increment.
   assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

   // Payloads are plain pass-throughs; only the valids/readies are gated.
   assign mem_req_rw     = r_rw;
   assign mem_req_addr   = r_addr;
   assign mem_wdata      = dc_wdata;
   assign mem_wmask      = dc_wmask;
   assign ic_resp_data   = mem_resp_data;
   assign dc_resp_data   = mem_resp_data;
   assign o_dbg_state    = r_state;
   assign o_dbg_beat_cnt = r_beat_cnt;

   // Next-state and handshake outputs for the current state.
   always_comb begin
      w_state_next    = r_state;
      w_req_fire      = 1'b0;
      w_beat_fire     = 1'b0;
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      mem_req_valid   = 1'b0;
      mem_wdata_valid = 1'b0;
      dc_wdata_ready  = 1'b0;
      ic_resp_valid   = 1'b0;
      dc_resp_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            ic_req_ready = w_run & ic_req_valid & ~w_grant_dc;
            dc_req_ready = w_run & w_grant_dc;
            w_req_fire   = w_run & (ic_req_valid | dc_req_valid);
            if (w_req_fire) w_state_next = S_REQ;
         end
         S_REQ: begin
            mem_req_valid = w_run;
            if (mem_req_ready) w_state_next = r_rw ? S_WDATA : S_RESP;
         end
         S_WDATA: begin
            mem_wdata_valid = w_run & dc_wdata_valid;
            dc_wdata_ready  = w_run & mem_wdata_ready;
            w_beat_fire     = dc_wdata_valid & mem_wdata_ready;
            if (w_beat_fire && w_last_beat) w_state_next = S_IDLE;
         end
         S_RESP: begin
            ic_resp_valid = w_run & mem_resp_valid & ~r_owner;
            dc_resp_valid = w_run & mem_resp_valid & r_owner;
            w_beat_fire   = mem_resp_valid;
            if (w_beat_fire && w_last_beat) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register, grant latch and beat counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b0;
         r_rw         <= 1'b0;
         r_addr       <= '0;
         r_beat_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_req_fire) begin
            r_owner      <= w_grant_dc;
            r_last_grant <= w_grant_dc;
            r_rw         <= w_grant_dc & dc_req_rw;
            r_addr       <= w_grant_dc ? dc_req_addr : ic_req_addr;
            r_beat_cnt   <= '0;
         end else if (w_beat_fire) begin
            r_beat_cnt   <= r_beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule
